// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit: MEM-stage load/store unit on a split addr/data bus       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic [DATA_W-1:0]   rt_value,
  input  logic [1:0]          mem_type,
  input  logic [1:0]          mem_size,
  input  logic                mem_signed,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   result,
  output logic                address_error
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, next_state;

  logic              err;
  logic              is_store;
  logic              is_access;
  logic              accept;
  logic              complete;
  logic              report;
  logic              cancel_set;
  logic              cancel;
  logic              lat_load;
  logic              lat_sgn;
  logic [OFF_W-1:0]  lat_off;
  logic [DATA_W-1:0] lat_ex;
  logic [B-1:0]      strobe;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_val;
  logic              sign;
  int                nbytes;
  int                lo;
  int                nbits;
  int                sign_idx;

  assign in_ready  = (state == IDLE);
  assign req       = (state == ADDR);
  assign is_store  = (mem_type == 2'd2);
  assign is_access = ((mem_type == 2'd1) || is_store) && !err;
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    err = 1'b0;
    case (mem_size)
      2'd1:    err = address[0];
      2'd2:    err = |address[1:0];
      2'd3:    err = (|address[2:0]) || (DATA_W == 32);
      default: err = 1'b0;
    endcase
  end

  always_comb begin
    strobe = '0;
    nbytes = 1 << mem_size;
    lo     = int'(address[OFF_W-1:0]);
    for (int i = 0; i < B; i++) begin
      strobe[i] = (i >= lo) && (i < lo + nbytes);
    end
  end

  // Lane-shift the read word down, then extend from the access width.
  always_comb begin
    shifted  = rdata >> {lat_off, 3'b000};
    nbits    = 8 << size;
    sign_idx = (nbits > DATA_W) ? DATA_W - 1 : nbits - 1;
    sign     = 1'b0;
    load_val = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == sign_idx) sign = lat_sgn & shifted[i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      load_val[i] = (i < nbits) ? shifted[i] : sign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    report     = 1'b0;
    cancel_set = 1'b0;
    case (state)
      IDLE: if (accept && is_access) next_state = ADDR;
      ADDR: begin
        if (addr_ok) begin
          if (data_ok) begin
            next_state = IDLE;
            complete   = 1'b1;
            report     = !flush;
          end else begin
            next_state = DATA;
            cancel_set = flush;
          end
        end else if (flush) begin
          next_state = IDLE;
        end
      end
      DATA: begin
        if (data_ok) begin
          next_state = IDLE;
          complete   = 1'b1;
          report     = !(cancel || flush);
        end else begin
          cancel_set = flush;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr            <= 1'b0;
      size          <= '0;
      addr          <= '0;
      wstrb         <= '0;
      wdata         <= '0;
      out_valid     <= 1'b0;
      result        <= '0;
      address_error <= 1'b0;
      cancel        <= 1'b0;
      lat_load      <= 1'b0;
      lat_sgn       <= 1'b0;
      lat_off       <= '0;
      lat_ex        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        size     <= mem_size;
        addr     <= address;
        lat_off  <= address[OFF_W-1:0];
        lat_sgn  <= mem_signed;
        lat_ex   <= ex_result;
        lat_load <= (mem_type == 2'd1);
        wr       <= is_store && !err;
        wstrb    <= (is_store && !err) ? strobe : '0;
        wdata    <= rt_value << {address[OFF_W-1:0], 3'b000};
        cancel   <= 1'b0;
        // Noops and faulting accesses never touch the bus.
        if (!is_access) begin
          out_valid     <= 1'b1;
          result        <= ex_result;
          address_error <= err;
        end
      end
      if (cancel_set) cancel <= 1'b1;
      if (complete && report) begin
        out_valid     <= 1'b1;
        result        <= lat_load ? load_val : lat_ex;
        address_error <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
